// File: rtl/aircon_ctrl_p_if.sv
// rtl/aircon_ctrl_p_if.sv - front-panel write port bundle for aircon_ctrl_p
// Signals: sel (target setting), wr_en (write strobe), val (unsigned value).
// master: front-panel decoder side; slave: aircon_ctrl_p side.
interface aircon_ctrl_p_if #(
  parameter int W = 5
) ();
  logic [1:0]   sel;
  logic         wr_en;
  logic [W-1:0] val;

  modport master (output sel, output wr_en, output val);
  modport slave  (input  sel, input  wr_en, input  val);
endinterface

// File: rtl/aircon_ctrl_p.sv
// rtl/aircon_ctrl_p.sv - clamped air-conditioner setting store with power FSM and timer
// Ports: clk, rst (sync, active-high), pwr (power request level),
//        wr (aircon_ctrl_p_if.slave: sel/wr_en/val write port),
//        temp/cap/fan/timer (settings, 0 outside RUN), on (state is RUN),
//        expired (one-cycle pulse when the countdown reaches 0).
// Optional feature macro: AIRCON_FAN_RAMP_EN (fan steps toward its target
// once every RAMP_DIV cycles instead of jumping).
module aircon_ctrl_p #(
  parameter int W        = 5,
  parameter int TEMP_MIN = 17,
  parameter int TEMP_MAX = 30,
  parameter int TEMP_DEF = 24,
  parameter int CAP_MAX  = 3,
  parameter int FAN_MAX  = 7,
  parameter int TICK_DIV = 1000,
  parameter int RAMP_DIV = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pwr,
  aircon_ctrl_p_if.slave  wr,
  output logic [W-1:0]    temp,
  output logic [W-1:0]    cap,
  output logic [W-1:0]    fan,
  output logic [W-1:0]    timer,
  output logic            on,
  output logic            expired
);

  localparam int             PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_RUN  = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc;

  logic          wr_ok;
  logic          wr_timer;
  logic          wr_fan;
  logic          tick_wrap;
  logic          expire;
  logic          run_hold;
  logic [W-1:0]  temp_clamped;
  logic [W-1:0]  cap_clamped;
  logic [W-1:0]  fan_clamped;

  // A write only lands while RUN is sustained by pwr=1; a timer write
  // preempts the prescaler wrap of the same cycle, so it also cancels expiry.
  assign wr_ok     = (state == S_RUN) && pwr && wr.wr_en;
  assign wr_timer  = wr_ok && (wr.sel == 2'd3);
  assign wr_fan    = wr_ok && (wr.sel == 2'd2);
  assign tick_wrap = (state == S_RUN) && (timer != '0) && (presc == PRESC_LAST) && !wr_timer;
  assign expire    = tick_wrap && (timer == W'(1));
  assign run_hold  = (state == S_RUN) && (state_nxt == S_RUN);

  always_comb begin
    temp_clamped = wr.val;
    if (wr.val < W'(TEMP_MIN)) begin
      temp_clamped = W'(TEMP_MIN);
    end else if (wr.val > W'(TEMP_MAX)) begin
      temp_clamped = W'(TEMP_MAX);
    end
    cap_clamped = (wr.val > W'(CAP_MAX)) ? W'(CAP_MAX) : wr.val;
    fan_clamped = (wr.val > W'(FAN_MAX)) ? W'(FAN_MAX) : wr.val;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_OFF;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; LOCK deliberately ignores pwr=1 so re-arming needs a 0.
  always_comb begin
    state_nxt = state;
    case (state)
      S_OFF:   if (pwr) state_nxt = S_RUN;
      S_RUN: begin
        if (!pwr) begin
          state_nxt = S_OFF;
        end else if (expire) begin
          state_nxt = S_LOCK;
        end
      end
      S_LOCK:  if (!pwr) state_nxt = S_OFF;
      default: state_nxt = S_OFF;
    endcase
  end

  // Output logic
  always_comb begin
    on = (state == S_RUN);
  end

  // Settings and countdown. Anything other than staying in RUN either loads
  // power-up defaults (OFF->RUN) or clears, which keeps outputs 0 outside RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      temp    <= '0;
      cap     <= '0;
      timer   <= '0;
      presc   <= '0;
      expired <= 1'b0;
    end else begin
      expired <= expire;
      if (state_nxt != S_RUN) begin
        temp  <= '0;
        cap   <= '0;
        timer <= '0;
        presc <= '0;
      end else if (state != S_RUN) begin
        temp  <= W'(TEMP_DEF);
        cap   <= '0;
        timer <= '0;
        presc <= '0;
      end else begin
        if (wr_ok && (wr.sel == 2'd0)) temp <= temp_clamped;
        if (wr_ok && (wr.sel == 2'd1)) cap  <= cap_clamped;
        if (wr_timer) begin
          timer <= wr.val;
          presc <= '0;
        end else if (timer == '0) begin
          presc <= '0;
        end else if (tick_wrap) begin
          timer <= timer - W'(1);
          presc <= '0;
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

`ifdef AIRCON_FAN_RAMP_EN
  localparam int             RCW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RCW-1:0] RAMP_LAST = RCW'(RAMP_DIV - 1);

  logic [W-1:0]   fan_tgt;
  logic [RCW-1:0] ramp_cnt;

  // The ramp compares against the target held before this cycle's write, and
  // a new target never restarts the ramp counter mid-step.
  always_ff @(posedge clk) begin
    if (rst || !run_hold) begin
      fan      <= '0;
      fan_tgt  <= '0;
      ramp_cnt <= '0;
    end else begin
      if (fan != fan_tgt) begin
        if (ramp_cnt == RAMP_LAST) begin
          ramp_cnt <= '0;
          fan      <= (fan < fan_tgt) ? fan + W'(1) : fan - W'(1);
        end else begin
          ramp_cnt <= ramp_cnt + RCW'(1);
        end
      end else begin
        ramp_cnt <= '0;
      end
      if (wr_fan) fan_tgt <= fan_clamped;
    end
  end
`else
  // Without the ramp the applied speed is the clamped target itself.
  always_ff @(posedge clk) begin
    if (rst || !run_hold) begin
      fan <= '0;
    end else if (wr_fan) begin
      fan <= fan_clamped;
    end
  end
`endif

endmodule

// File: tb/tb_aircon_ctrl_p.sv
// tb/tb_aircon_ctrl_p.sv - self-checking bench for aircon_ctrl_p
module tb_aircon_ctrl_p;
  localparam int W  = 5;
  localparam int TD = 4;
  localparam int RD = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         pwr;
  logic [W-1:0] temp, cap, fan, timer;
  logic         on, expired;

  int checks = 0;
  int errors = 0;

  aircon_ctrl_p_if #(.W(W)) bus ();

  aircon_ctrl_p #(
    .W(W), .TEMP_MIN(17), .TEMP_MAX(30), .TEMP_DEF(24), .CAP_MAX(3),
    .FAN_MAX(7), .TICK_DIV(TD), .RAMP_DIV(RD)
  ) dut (
    .clk(clk), .rst(rst), .pwr(pwr), .wr(bus.slave),
    .temp(temp), .cap(cap), .fan(fan), .timer(timer),
    .on(on), .expired(expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Behavioural model: mode 0=off, 1=run, 2=lock.
  int m_mode, m_temp, m_cap, m_fan, m_tgt, m_timer, m_ticks, m_rcnt;
  bit m_exp;
  bit m_valid = 1'b0;

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic m_clear();
    m_temp = 0; m_cap = 0; m_fan = 0; m_tgt = 0;
    m_timer = 0; m_ticks = 0; m_rcnt = 0;
  endtask

  always @(posedge clk) begin
    m_exp = 1'b0;
    if (rst) begin
      m_valid = 1'b1;
      m_mode = 0;
      m_clear();
    end else if (m_valid) begin
      case (m_mode)
        0: if (pwr) begin
          m_mode = 1;
          m_clear();
          m_temp = 24;
        end
        1: begin
          if (!pwr) begin
            if (m_timer == 1 && m_ticks == TD - 1) m_exp = 1'b1;
            m_mode = 0;
            m_clear();
          end else begin
`ifdef AIRCON_FAN_RAMP_EN
            if (m_fan != m_tgt) begin
              m_rcnt++;
              if (m_rcnt == RD) begin
                m_rcnt = 0;
                m_fan += (m_fan < m_tgt) ? 1 : -1;
              end
            end else begin
              m_rcnt = 0;
            end
`endif
            if (bus.wr_en) begin
              case (bus.sel)
                2'd0: m_temp = clamp(int'(bus.val), 17, 30);
                2'd1: m_cap  = clamp(int'(bus.val), 0, 3);
`ifdef AIRCON_FAN_RAMP_EN
                2'd2: m_tgt  = clamp(int'(bus.val), 0, 7);
`else
                2'd2: m_fan  = clamp(int'(bus.val), 0, 7);
`endif
                default: begin m_timer = int'(bus.val); m_ticks = 0; end
              endcase
            end
            if (!(bus.wr_en && bus.sel == 2'd3) && m_timer != 0) begin
              if (m_ticks == TD - 1) begin
                m_ticks = 0;
                m_timer--;
                if (m_timer == 0) begin
                  m_exp = 1'b1;
                  m_mode = 2;
                  m_clear();
                end
              end else begin
                m_ticks++;
              end
            end
          end
        end
        default: if (!pwr) m_mode = 0;
      endcase
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_temp",    int'(temp),    m_temp);
      chk("model_cap",     int'(cap),     m_cap);
      chk("model_fan",     int'(fan),     m_fan);
      chk("model_timer",   int'(timer),   m_timer);
      chk("model_on",      int'(on),      (m_mode == 1) ? 1 : 0);
      chk("model_expired", int'(expired), int'(m_exp));
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(input int s, input int v);
    bus.wr_en = 1'b1;
    bus.sel   = 2'(s);
    bus.val   = W'(v);
    cyc();
    bus.wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pwr = 1'b0;
    bus.wr_en = 1'b0; bus.sel = 2'd0; bus.val = '0;
    cyc(3);
    chk("reset_temp", int'(temp), 0);
    chk("reset_on", int'(on), 0);
    chk("reset_timer", int'(timer), 0);
    rst = 1'b0;
    pwr = 1'b1;
    wr(0, 20);
    chk("powerup_on", int'(on), 1);
    chk("powerup_temp_write_dropped", int'(temp), 24);
    chk("powerup_cap", int'(cap), 0);

    wr(0, 10); chk("clamp_temp_low", int'(temp), 17);
    wr(0, 31); chk("clamp_temp_high", int'(temp), 30);
    wr(0, 20); chk("temp_pass", int'(temp), 20);
    wr(1, 9);  chk("clamp_cap", int'(cap), 3);
    wr(2, 15);
`ifdef AIRCON_FAN_RAMP_EN
    cyc(27);   chk("ramp_up_27", int'(fan), 6);
    cyc(1);    chk("ramp_up_28", int'(fan), 7);
    wr(2, 3);
    cyc(16);   chk("ramp_down", int'(fan), 3);
`else
    chk("fan_clamp", int'(fan), 7);
`endif

    wr(3, 2);  chk("timer_load", int'(timer), 2);
    cyc(4);    chk("timer_dec1", int'(timer), 1);
    cyc(4);    chk("timer_zero", int'(timer), 0);
    chk("expired_pulse", int'(expired), 1);
    chk("expired_on", int'(on), 0);
    cyc(1);    chk("expired_once", int'(expired), 0);
    cyc(3);    chk("lock_holds", int'(on), 0);
    chk("lock_temp", int'(temp), 0);
    wr(0, 20); chk("lock_write_dropped", int'(temp), 0);
    pwr = 1'b0; cyc();
    pwr = 1'b1; cyc();
    chk("rearm_on", int'(on), 1);
    chk("rearm_temp", int'(temp), 24);

    wr(3, 1);
    cyc(3);
    wr(3, 5);
    chk("collision_timer", int'(timer), 5);
    chk("collision_no_expire", int'(expired), 0);
    chk("collision_on", int'(on), 1);
    cyc(3);    chk("collision_presc_hold", int'(timer), 5);
    cyc(1);    chk("collision_presc_wrap", int'(timer), 4);

    pwr = 1'b0; cyc();
    chk("powerdown_timer", int'(timer), 0);
    chk("powerdown_temp", int'(temp), 0);
    wr(0, 20); chk("off_write_dropped", int'(temp), 0);
    pwr = 1'b1; cyc();

    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 499) == 0);
      pwr       = ($urandom_range(0, 59) != 0);
      bus.wr_en = ($urandom_range(0, 7) == 0);
      bus.sel   = 2'($urandom_range(0, 3));
      bus.val   = W'($urandom_range(0, 31));
      cyc();
    end
    rst = 1'b0; bus.wr_en = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aircon_ctrl_p.md
# aircon_ctrl_p

Parametrised, clocked successor to the power-gated air-conditioner setting store. It holds temperature, capacity, fan-speed and timer settings behind a single select/value write port, and clamps every write to configurable bounds. It adds a power state machine, a countdown timer with auto-off and lockout, and an optional fan ramp. It sits between the front-panel decoder, which drives `sel`/`val`/`wr_en`, and the compressor/fan drivers, which consume the outputs.

## Interface
- `W`, 5: width of the value bus and of every setting output.
- `TEMP_MIN`, 17: lowest accepted temperature code.
- `TEMP_MAX`, 30: highest accepted temperature code.
- `TEMP_DEF`, 24: temperature loaded on power-up.
- `CAP_MAX`, 3: highest capacity code.
- `FAN_MAX`, 7: highest fan-speed code.
- `TICK_DIV`, 1000: clock cycles per timer decrement; must be ≥2.
- `RAMP_DIV`, 4: clock cycles per fan step; used only with ramp enabled.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `pwr` input 1: power request, level-sensitive.
- `sel` input 2: target setting; 0=temp, 1=cap, 2=fan, 3=timer.
- `wr_en` input 1: write strobe, one write per cycle.
- `val` input W: value to write (unsigned).
- `temp` output W: current temperature setting.
- `cap` output W: current capacity setting.
- `fan` output W: current applied fan speed.
- `timer` output W: remaining timer ticks; 0 means the timer is disabled.
- `on` output 1: high while the FSM is in RUN.
- `expired` output 1: one-cycle pulse when the timer reaches 0 by countdown.

## Operation
- FSM states are OFF, RUN and LOCK. Reset state is OFF.
- OFF→RUN when `pwr`=1. At that edge: temp=TEMP_DEF; cap, fan, fan target, timer and prescaler all =0.
- RUN→OFF when `pwr`=0.
- RUN→LOCK on timer expiry while `pwr`=1.
- LOCK→OFF when `pwr`=0. LOCK ignores `pwr`=1, so re-arming requires a 0 then a 1.
- Entering OFF or LOCK clears temp, cap, fan, fan target, timer and prescaler to 0. All outputs stay 0 outside RUN.
- Writes are accepted only when state=RUN, `pwr`=1 and `wr_en`=1; otherwise they are dropped.
- Write clamping, unsigned compare:
  - temp: `val`<TEMP_MIN gives TEMP_MIN; `val`>TEMP_MAX gives TEMP_MAX; otherwise `val`.
  - cap: min(`val`, CAP_MAX).
  - fan target: min(`val`, FAN_MAX).
  - timer: `val` unclamped.
- A timer write also clears the prescaler.
- Timer countdown:
  - While RUN and timer≠0, the prescaler counts 0..TICK_DIV-1, then wraps.
  - Each wrap decrements timer by 1.
  - A decrement from 1 to 0 pulses `expired` and moves the FSM to LOCK.
  - While timer=0 the prescaler holds at 0.
- Simultaneous events:
  - Timer write in the same cycle as a wrap: the write wins, with no decrement and no expiry.
  - `pwr`=0 in the same cycle as expiry: go to OFF; `expired` still pulses.
- `rst` overrides everything, including a mid-countdown timer or a ramp in progress.

## Timing
- Reset values: state=OFF; temp=cap=fan=timer=0; `on`=0; `expired`=0; prescaler and ramp counter =0.
- `on` rises one cycle after the first `pwr`=1 sample in OFF. A write in that same sample cycle is dropped.
- Write latency: the clamped value appears on the output the cycle after `wr_en`. `fan` follows this latency only with ramp disabled.
- Expiry: `expired` and the final timer=0 appear on the same edge; `on`=0 from that edge.
- Power-down: outputs read 0 the cycle after `pwr`=0 is sampled.

## Configuration
- `AIRCON_FAN_RAMP_EN` defined:
  - While RUN and `fan`≠target, a ramp counter counts 0..RAMP_DIV-1.
  - On each wrap, `fan` moves one step toward the target.
  - The ramp counter holds at 0 when `fan`=target.
  - A new target write does not reset the ramp counter.
- `AIRCON_FAN_RAMP_EN` undefined:
  - `fan` equals the clamped target one cycle after the write.
  - No ramp counter is instantiated; `RAMP_DIV` is unused.

## Test plan
- Reset and power-up: hold `rst` 3 cycles, then `pwr`=1 → all outputs 0 during reset; next cycle `on`=1, temp=24, cap=fan=timer=0.
- Clamping: writes temp=10, temp=31, temp=20, cap=9, fan=15 → temp reads 17, then 30, then 20; cap=3; fan target=7.
- Timer expiry (TICK_DIV=4): write timer=2 → timer=1 after 4 cycles, 0 after 8. `expired` pulses once; `on`=0; outputs 0; holding `pwr`=1 keeps LOCK. `pwr` 0→1 → RUN again with defaults.
- Write/wrap collision: write timer=5 on the wrap cycle of timer=1 → timer=5, no `expired`, prescaler restarts from 0.
- Fan ramp (macro on, RAMP_DIV=4): fan target 0→7 → `fan` reaches 7 after 28 cycles. Target 3 → `fan` steps down to 3. Macro off: `fan`=7 one cycle after the write.
- Dropped writes and mid-operation power loss: `wr_en` in OFF or LOCK → no change. `pwr`=0 mid-ramp or mid-countdown → all outputs 0 next cycle; the next power-up loads defaults.
